// File: rtl/cpu_pkg.sv
// Shared CPU control types: FSM states, opcode map, ALUOp classes, mux selects, control word.
// Pure definitions; no timing or backpressure of its own.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_R_WB     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_I_WB     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_SLTI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b0101;
    localparam logic [3:0] OP_SW    = 4'b0110;
    localparam logic [3:0] OP_BNE   = 4'b0111;
    localparam logic [3:0] OP_J     = 4'b1000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BNE   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [2:0] alu_opcode;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_itype(input logic [3:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_ADDI) || (op == OP_SLTI);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_J;
    endfunction

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational state -> control word for the multicycle CPU.
// Zero latency; only FETCH/MEM_WR enables and the illegal flag look at live inputs.
module main_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    input  logic [3:0] i_opcode,
    input  logic [2:0] i_alu_opc,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_TWO;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH;
                o_ctrl.illegal   = !is_legal(i_opcode);
            end
            ST_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REGB;
                o_ctrl.alu_op    = ALUOP_RTYPE;
            end
            ST_R_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_EXEC_I: begin
                o_ctrl.alu_src_a  = 1'b1;
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.alu_op     = ALUOP_ITYPE;
                o_ctrl.alu_opcode = i_alu_opc;
            end
            ST_I_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                // Store retires in the cycle memory accepts it.
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.iord       = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REGB;
                o_ctrl.alu_op        = ALUOP_BNE;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: sequences datapath enables, counts retired instructions.
// R/I/SW 4 cycles, LW 5, BNE/J 3, illegal 2; each MemReady=0 cycle in FETCH/MEM_RD/MEM_WR adds one.
module multicycle_main_control
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       Opcode,
    input  logic             MemReady,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ALUOpcode,
    output logic             InstrDone,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_alu_opc;
    logic [CNT_W-1:0] r_instr_count;
    ctrl_t            w_ctrl;
    ctrl_t            w_out;

    // Zero is consumed by the PC write gate in the datapath, not by this FSM.
    logic w_unused_zero;
    assign w_unused_zero = Zero;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_FETCH:    w_next_state = MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (Opcode == OP_RTYPE)                    w_next_state = ST_EXEC_R;
                else if (is_itype(Opcode))                 w_next_state = ST_EXEC_I;
                else if (Opcode == OP_LW || Opcode == OP_SW) w_next_state = ST_MEM_ADDR;
                else if (Opcode == OP_BNE)                 w_next_state = ST_BRANCH;
                else if (Opcode == OP_J)                   w_next_state = ST_JUMP;
                else                                       w_next_state = ST_FETCH;
            end
            ST_EXEC_R:   w_next_state = ST_R_WB;
            ST_EXEC_I:   w_next_state = ST_I_WB;
            ST_MEM_ADDR: w_next_state = (Opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   w_next_state = MemReady ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   w_next_state = MemReady ? ST_FETCH : ST_MEM_WR;
            default:     w_next_state = ST_FETCH;
        endcase
    end

    // The I-format sub-opcode is captured in DECODE so later IR churn cannot leak into EXEC_I.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_alu_opc     <= '0;
            r_instr_count <= '0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_alu_opc <= Opcode[2:0];
            end
            if (w_ctrl.instr_done) begin
                r_instr_count <= r_instr_count + CNT_ONE;
            end
        end
    end

    main_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (MemReady),
        .i_opcode    (Opcode),
        .i_alu_opc   (r_alu_opc),
        .o_ctrl      (w_ctrl)
    );

    assign w_out = Reset ? '0 : w_ctrl;

    assign PCWrite     = w_out.pc_write;
    assign PCWriteCond = w_out.pc_write_cond;
    assign IorD        = w_out.iord;
    assign MemRead     = w_out.mem_read;
    assign MemWrite    = w_out.mem_write;
    assign IRWrite     = w_out.ir_write;
    assign MemtoReg    = w_out.mem_to_reg;
    assign RegWrite    = w_out.reg_write;
    assign RegDst      = w_out.reg_dst;
    assign ALUSrcA     = w_out.alu_src_a;
    assign ALUSrcB     = w_out.alu_src_b;
    assign PCSource    = w_out.pc_source;
    assign ALUOp       = w_out.alu_op;
    assign ALUOpcode   = w_out.alu_opcode;
    assign InstrDone   = w_out.instr_done;
    assign Illegal     = w_out.illegal;
    assign InstrCount  = Reset ? '0 : r_instr_count;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control with a 2-bit retire counter so wrap is reachable.
module tb_multicycle_main_control;

    logic       Clock;
    logic       Reset;
    logic [3:0] Opcode;
    logic       MemReady;
    logic       Zero;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic [2:0] ALUOpcode;
    logic       InstrDone, Illegal;
    logic [1:0] InstrCount;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    multicycle_main_control #(.CNT_W(2)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .Zero        (Zero),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUOpcode   (ALUOpcode),
        .InstrDone   (InstrDone),
        .Illegal     (Illegal),
        .InstrCount  (InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [20:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, ALUOpcode,
                   InstrDone, Illegal};

    function automatic logic [20:0] cw(
        input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca,
        input logic [1:0] srcb, pcs, aop,
        input logic [2:0] aopc,
        input logic done, ill);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, srcb, pcs, aop, aopc, done, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One FSM cycle: drive inputs, check outputs mid-cycle, then advance past the next edge.
    task automatic run_cycle(input string tag, input logic rst, input logic rdy, input logic [20:0] exp);
        Reset    = rst;
        MemReady = rdy;
        #1;
        if (rst) exp_cnt = 0;
        check(tag, 32'(outs), 32'(exp));
        check({tag, "/cnt"}, 32'(InstrCount), 32'(exp_cnt));
        if (!rst && exp[1]) exp_cnt = (exp_cnt + 1) % 4;
        @(posedge Clock);
        #1;
    endtask

    logic [20:0] cw_rst, cw_fetch, cw_fstall, cw_dec, cw_dec_ill, cw_exi_addi, cw_iwb;
    logic [20:0] cw_exr, cw_rwb, cw_ma, cw_mrd, cw_mwb, cw_mwr_go, cw_mwr_wait, cw_br, cw_jmp;

    initial begin
        cw_rst      = '0;
        cw_fetch    = cw(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 3'b000, 0,0);
        cw_fstall   = cw(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 3'b000, 0,0);
        cw_dec      = cw(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 3'b000, 0,0);
        cw_dec_ill  = cw(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 3'b000, 0,1);
        cw_exi_addi = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b11, 3'b011, 0,0);
        cw_iwb      = cw(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 1,0);
        cw_exr      = cw(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b10, 3'b000, 0,0);
        cw_rwb      = cw(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 3'b000, 1,0);
        cw_ma       = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 3'b000, 0,0);
        cw_mrd      = cw(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0,0);
        cw_mwb      = cw(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 1,0);
        cw_mwr_go   = cw(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 1,0);
        cw_mwr_wait = cw(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0,0);
        cw_br       = cw(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 3'b000, 1,0);
        cw_jmp      = cw(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 1,0);

        Reset = 1'b1; MemReady = 1'b1; Zero = 1'b0; Opcode = 4'b0011;
        @(posedge Clock);
        #1;
        run_cycle("rst0", 1, 1, cw_rst);
        run_cycle("rst1", 1, 1, cw_rst);

        // ADDI
        run_cycle("addi_fetch", 0, 1, cw_fetch);
        run_cycle("addi_dec",   0, 1, cw_dec);
        run_cycle("addi_exi",   0, 1, cw_exi_addi);
        run_cycle("addi_wb",    0, 1, cw_iwb);

        // R-format
        Opcode = 4'b0000;
        run_cycle("r_fetch", 0, 1, cw_fetch);
        run_cycle("r_dec",   0, 1, cw_dec);
        run_cycle("r_exr",   0, 1, cw_exr);
        run_cycle("r_wb",    0, 1, cw_rwb);

        // LW with three stall cycles in MEM_RD
        Opcode = 4'b0101;
        run_cycle("lw_fetch", 0, 1, cw_fetch);
        run_cycle("lw_dec",   0, 1, cw_dec);
        run_cycle("lw_ma",    0, 1, cw_ma);
        run_cycle("lw_rd_w0", 0, 0, cw_mrd);
        run_cycle("lw_rd_w1", 0, 0, cw_mrd);
        run_cycle("lw_rd_w2", 0, 0, cw_mrd);
        run_cycle("lw_rd_go", 0, 1, cw_mrd);
        run_cycle("lw_wb",    0, 1, cw_mwb);

        // BNE, Zero=0 then Zero=1 (fourth retire wraps the 2-bit counter)
        Opcode = 4'b0111; Zero = 1'b0;
        run_cycle("bne0_fetch", 0, 1, cw_fetch);
        run_cycle("bne0_dec",   0, 1, cw_dec);
        run_cycle("bne0_br",    0, 1, cw_br);
        Zero = 1'b1;
        run_cycle("bne1_fetch", 0, 1, cw_fetch);
        run_cycle("bne1_dec",   0, 1, cw_dec);
        run_cycle("bne1_br",    0, 1, cw_br);
        Zero = 1'b0;

        // J with one fetch stall
        Opcode = 4'b1000;
        run_cycle("j_fstall", 0, 0, cw_fstall);
        run_cycle("j_fetch",  0, 1, cw_fetch);
        run_cycle("j_dec",    0, 1, cw_dec);
        run_cycle("j_jump",   0, 1, cw_jmp);

        // SW, immediate ready
        Opcode = 4'b0110;
        run_cycle("sw_fetch", 0, 1, cw_fetch);
        run_cycle("sw_dec",   0, 1, cw_dec);
        run_cycle("sw_ma",    0, 1, cw_ma);
        run_cycle("sw_wr",    0, 1, cw_mwr_go);

        // Illegal opcode
        Opcode = 4'b1011;
        run_cycle("ill_fetch",  0, 1, cw_fetch);
        run_cycle("ill_dec",    0, 1, cw_dec_ill);
        run_cycle("ill_refetch",0, 0, cw_fstall);

        // ADDI with the opcode input disturbed after DECODE
        Opcode = 4'b0011;
        run_cycle("addi2_fetch", 0, 1, cw_fetch);
        run_cycle("addi2_dec",   0, 1, cw_dec);
        Opcode = 4'b0001;
        run_cycle("addi2_exi",   0, 1, cw_exi_addi);
        run_cycle("addi2_wb",    0, 1, cw_iwb);

        // J to make the counter non-zero, then reset during a MEM_WR stall
        Opcode = 4'b1000;
        run_cycle("j2_fetch", 0, 1, cw_fetch);
        run_cycle("j2_dec",   0, 1, cw_dec);
        run_cycle("j2_jump",  0, 1, cw_jmp);
        Opcode = 4'b0110;
        run_cycle("swr_fetch", 0, 1, cw_fetch);
        run_cycle("swr_dec",   0, 1, cw_dec);
        run_cycle("swr_ma",    0, 1, cw_ma);
        run_cycle("swr_wait",  0, 0, cw_mwr_wait);
        run_cycle("swr_rst",   1, 1, cw_rst);
        run_cycle("swr_after", 0, 1, cw_fetch);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
